// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types and constants: producer channel indices and the buffered result record.
package wb_arbiter_pkg;

    localparam int unsigned WB_XLEN          = 32;
    localparam int unsigned WB_RF_ADDR_WIDTH = 5;

    localparam int unsigned WB_NUM_SRC = 3;
    localparam int unsigned WB_SRC_ALU = 0;
    localparam int unsigned WB_SRC_LSU = 1;
    localparam int unsigned WB_SRC_MDU = 2;

    typedef struct packed {
        logic [WB_RF_ADDR_WIDTH-1:0] rd;
        logic [WB_XLEN-1:0]          data;
    } wb_req_t;

    // Round-robin successor of idx among n channels.
    function automatic int unsigned wb_rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback records; full/empty are decoded from the registered count.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t din,
    output wb_req_t dout,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read once the count covers it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers each producer's results, round-robins them onto the register-file
// write port, and keeps the busy mask decode uses for RAW/WAW stalls.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN                = WB_XLEN,
    parameter int unsigned REG_FILE_ADDR_WIDTH = WB_RF_ADDR_WIDTH,
    parameter int unsigned REG_FILE_DEPTH      = 32,
    parameter int unsigned NUM_SRC             = WB_NUM_SRC,
    parameter int unsigned FIFO_DEPTH          = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_SRC-1:0]                 src_valid,
    output logic [NUM_SRC-1:0]                 src_ready,
    input  logic [NUM_SRC*REG_FILE_ADDR_WIDTH-1:0] src_rd,
    input  logic [NUM_SRC*XLEN-1:0]            src_data,
    input  logic                               issue_en,
    input  logic [REG_FILE_ADDR_WIDTH-1:0]     issue_rd,
    output logic [REG_FILE_DEPTH-1:0]          busy,
    output logic                               rd_wr_en,
    output logic [REG_FILE_ADDR_WIDTH-1:0]     rd_addr,
    output logic [XLEN-1:0]                    rd_data
);

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    wb_req_t              fifo_din  [NUM_SRC];
    wb_req_t              fifo_dout [NUM_SRC];
    logic [NUM_SRC-1:0]   fifo_full;
    logic [NUM_SRC-1:0]   fifo_empty;
    logic [NUM_SRC-1:0]   fifo_push;
    logic [NUM_SRC-1:0]   fifo_pop;

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     grant_idx;
    logic                 found;
    int unsigned          idx;
    wb_req_t              pop_req;
    logic                 wr_fire;

    logic [REG_FILE_DEPTH-1:0]      busy_q, busy_d;
    logic                           rd_wr_en_q;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr_q;
    logic [XLEN-1:0]                rd_data_q;

    // Ready comes from the registered full flag only, never from valid or the pop.
    assign src_ready = ~fifo_full;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign fifo_din[g].rd   = src_rd[g*REG_FILE_ADDR_WIDTH +: REG_FILE_ADDR_WIDTH];
        assign fifo_din[g].data = src_data[g*XLEN +: XLEN];
        assign fifo_push[g]     = src_valid[g] && !fifo_full[g];

        wb_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[g]),
            .pop   (fifo_pop[g]),
            .din   (fifo_din[g]),
            .dout  (fifo_dout[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    // First non-empty FIFO at or after the pointer wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = ptr_q;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = (32'(ptr_q) + k) % NUM_SRC;
            if (!found && !fifo_empty[idx]) begin
                found     = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        fifo_pop = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            fifo_pop[i] = found && (32'(grant_idx) == i);
        end
    end

    assign pop_req = fifo_dout[grant_idx];
    // x0 entries are consumed but never reach the register file.
    assign wr_fire = found && (pop_req.rd != '0);
    assign ptr_d   = found ? PTR_W'(wb_rr_next(32'(grant_idx), NUM_SRC)) : ptr_q;

    // Set is applied after clear so a same-cycle reissue of r keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_fire) begin
            busy_d[pop_req.rd] = 1'b0;
        end
        if (issue_en && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            busy_q     <= '0;
            rd_wr_en_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            rd_wr_en_q <= wr_fire;
            if (wr_fire) begin
                rd_addr_q <= pop_req.rd;
                rd_data_q <= pop_req.data;
            end
        end
    end

    assign busy     = busy_q;
    assign rd_wr_en = rd_wr_en_q;
    assign rd_addr  = rd_addr_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-producer expected-write queues plus targeted checks.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [14:0] src_rd;
    logic [95:0] src_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic        rd_wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int total;
    int bad;

    wb_req_t    q_alu[$];
    wb_req_t    q_lsu[$];
    wb_req_t    q_mdu[$];
    logic [4:0] wr_log[$];
    int         src_of_rd [32];
    logic [2:0] last_acc;

    wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_rd    (src_rd),
        .src_data  (src_data),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .busy      (busy),
        .rd_wr_en  (rd_wr_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic int q_size(input int s);
        if (s == int'(WB_SRC_ALU)) return q_alu.size();
        if (s == int'(WB_SRC_LSU)) return q_lsu.size();
        if (s == int'(WB_SRC_MDU)) return q_mdu.size();
        return 0;
    endfunction

    task automatic q_push(input int s, input wb_req_t e);
        if (s == int'(WB_SRC_ALU)) q_alu.push_back(e);
        else if (s == int'(WB_SRC_LSU)) q_lsu.push_back(e);
        else q_mdu.push_back(e);
    endtask

    task automatic q_pop(input int s, output wb_req_t e);
        if (s == int'(WB_SRC_ALU)) e = q_alu.pop_front();
        else if (s == int'(WB_SRC_LSU)) e = q_lsu.pop_front();
        else e = q_mdu.pop_front();
    endtask

    task automatic observe();
        wb_req_t e;
        int      s;
        if (rd_wr_en === 1'b1) begin
            s = src_of_rd[rd_addr];
            wr_log.push_back(rd_addr);
            total++;
            assert (q_size(s) != 0) else begin
                bad++;
                $error("FAIL unexpected_write got=rd%0d:%h want=no_write", rd_addr, rd_data);
            end
            if (q_size(s) != 0) begin
                q_pop(s, e);
                check("write", 64'({rd_addr, rd_data}), 64'({e.rd, e.data}));
            end
        end
    endtask

    // Drive one cycle of stimulus, record accepted pushes, then sample 1 time unit after the edge.
    task automatic step(input logic [2:0] v, input logic [14:0] rds, input logic [95:0] ds,
                        input logic ie, input logic [4:0] ird);
        wb_req_t    e;
        logic [4:0] r;
        src_valid = v;
        src_rd    = rds;
        src_data  = ds;
        issue_en  = ie;
        issue_rd  = ird;
        last_acc  = v & src_ready;
        for (int i = 0; i < 3; i++) begin
            r = rds[i*5 +: 5];
            if (last_acc[i] && r != 5'd0) begin
                e.rd   = r;
                e.data = ds[i*32 +: 32];
                q_push(i, e);
                src_of_rd[r] = i;
            end
        end
        @(posedge clk);
        #1;
        src_valid = 3'b000;
        issue_en  = 1'b0;
        observe();
    endtask

    task automatic idle();
        step(3'b000, 15'd0, 96'd0, 1'b0, 5'd0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q_alu.size() + q_lsu.size() + q_mdu.size()) != 0 && n < 20) begin
            idle();
            n++;
        end
        check(tag, 64'(q_alu.size() + q_lsu.size() + q_mdu.size()), 64'd0);
        idle();
        idle();
    endtask

    initial begin
        int          li;
        int          lsu_writes;
        logic [4:0]  prev;
        logic [4:0]  nxt;

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        src_valid = 3'b000;
        src_rd    = '0;
        src_data  = '0;
        issue_en  = 1'b0;
        issue_rd  = '0;
        for (int i = 0; i < 32; i++) src_of_rd[i] = -1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_en", 64'(rd_wr_en), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", 64'(src_ready), 64'h7);
        check("rst_addr", 64'(rd_addr), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);

        // Single write through the ALU channel
        step(3'b000, 15'd0, 96'd0, 1'b1, 5'd5);
        check("single_busy_set", 64'(busy), 64'h20);
        step(3'b001, {10'd0, 5'd5}, {64'd0, 32'hDEAD_BEEF}, 1'b0, 5'd0);
        check("single_no_early", 64'(rd_wr_en), 64'd0);
        check("single_busy_held", 64'(busy[5]), 64'd1);
        idle();
        check("single_wr_en", 64'(rd_wr_en), 64'd1);
        check("single_addr", 64'(rd_addr), 64'd5);
        check("single_data", 64'(rd_data), 64'hDEAD_BEEF);
        check("single_busy_clr", 64'(busy[5]), 64'd0);
        idle();
        check("single_pulse", 64'(rd_wr_en), 64'd0);

        // Round-robin with all producers pushing every cycle
        wr_log.delete();
        for (int n = 0; n < 12; n++) begin
            step(3'b111, {5'd3, 5'd2, 5'd1},
                 {8'd2, 24'(n), 8'd1, 24'(n), 8'd0, 24'(n)}, 1'b0, 5'd0);
        end
        check("rr_count", 64'(wr_log.size()), 64'd11);
        for (int i = 1; i < wr_log.size(); i++) begin
            prev = wr_log[i-1];
            nxt  = (prev == 5'd3) ? 5'd1 : prev + 5'd1;
            check("rr_order", 64'(wr_log[i]), 64'(nxt));
        end
        drain("rr_drain");

        // Reset mid-stream with queued entries and pending busy bits
        step(3'b000, 15'd0, 96'd0, 1'b1, 5'd4);
        step(3'b000, 15'd0, 96'd0, 1'b1, 5'd5);
        check("mid_busy_pre", 64'(busy), 64'h30);
        step(3'b011, {5'd0, 5'd5, 5'd4}, {32'd0, 32'h0000_00B5, 32'h0000_00A4}, 1'b0, 5'd0);
        check("mid_queued", 64'(q_alu.size() + q_lsu.size()), 64'd2);
        rst = 1'b1;
        #2;
        check("mid_busy_rst", 64'(busy), 64'd0);
        check("mid_wr_en_rst", 64'(rd_wr_en), 64'd0);
        q_alu.delete();
        q_lsu.delete();
        q_mdu.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_ready", 64'(src_ready), 64'h7);
        check("mid_busy_post", 64'(busy), 64'd0);
        wr_log.delete();
        repeat (4) idle();
        check("mid_no_stale", 64'(wr_log.size()), 64'd0);

        // LSU backpressure while ALU and MDU stay busy
        li = 0;
        wr_log.delete();
        for (int n = 0; n < 10; n++) begin
            step({1'b1, (li < 3), 1'b1}, {5'd10, 5'd9, 5'd8},
                 {8'hE0, 24'(n), 8'hC0, 24'(li), 8'hA0, 24'(n)}, 1'b0, 5'd0);
            if (last_acc[1] && li < 3) li++;
            if (n == 1) begin
                check("bp_ready_low", 64'(src_ready[1]), 64'd0);
                check("bp_two_pushed", 64'(li), 64'd2);
            end
        end
        check("bp_all_pushed", 64'(li), 64'd3);
        drain("bp_drain");
        lsu_writes = 0;
        foreach (wr_log[i]) if (wr_log[i] == 5'd9) lsu_writes++;
        check("bp_lsu_writes", 64'(lsu_writes), 64'd3);

        // x0 results are dropped
        step(3'b000, 15'd0, 96'd0, 1'b1, 5'd12);
        step(3'b000, 15'd0, 96'd0, 1'b1, 5'd0);
        check("x0_issue_ignored", 64'(busy), 64'h1000);
        step(3'b100, 15'd0, {32'h0000_1234, 64'd0}, 1'b0, 5'd0);
        check("x0_push_no_wr", 64'(rd_wr_en), 64'd0);
        idle();
        check("x0_pop_no_wr", 64'(rd_wr_en), 64'd0);
        check("x0_busy", 64'(busy), 64'h1000);
        step(3'b100, {5'd12, 10'd0}, {32'h0000_5678, 64'd0}, 1'b0, 5'd0);
        idle();
        check("x0_next_wr", 64'(rd_wr_en), 64'd1);
        check("x0_next_addr", 64'(rd_addr), 64'd12);
        check("x0_busy_clr", 64'(busy), 64'd0);

        // Same-edge set and clear of x7: set wins
        step(3'b000, 15'd0, 96'd0, 1'b1, 5'd7);
        step(3'b001, {10'd0, 5'd7}, {64'd0, 32'h0000_0077}, 1'b0, 5'd0);
        step(3'b000, 15'd0, 96'd0, 1'b1, 5'd7);
        check("col_wr_en", 64'(rd_wr_en), 64'd1);
        check("col_addr", 64'(rd_addr), 64'd7);
        check("col_busy", 64'(busy), 64'h80);
        idle();
        check("col_busy_held", 64'(busy[7]), 64'd1);

        check("end_empty", 64'(q_alu.size() + q_lsu.size() + q_mdu.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
